jericalla_issuer: RTL
=====================

# jericalla_issuer

Instruction issue unit for the Jericalla plus datapath. Holds a small loadable program store and, after a start pulse, drives the datapath's 17-bit instruction bus, presenting each word for a fixed number of clock cycles, one after another. It is the producer for the datapath's instruction input and replaces the hand-timed instruction sequence used at bench level.

## Interface
- DEPTH, 16: program store depth in 17-bit words.
- AW, 4: address width; DEPTH = 2**AW.
- HOLD_CYCLES, 2: cycles each instruction stays on the bus. Legal range is 1..255.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- load_en  in  1  write strobe for the program store.
- load_addr  in  AW  program store write address.
- load_data  in  17  instruction word: [16:15] opcode, [14:10] WA, [9:5] RA1, [4:0] RA2.
- prog_len  in  AW+1  number of instructions to issue. Sampled at start. Legal range is 1..DEPTH.
- start  in  1  single-cycle request to begin issuing.
- stop  in  1  request to end after the current instruction.
- instruccion  out  17  instruction bus to the datapath.
- issue_valid  out  1  high while instruccion carries a program word.
- first_cycle  out  1  high on the first cycle of each issued word.
- busy  out  1  high in ISSUE.
- done  out  1  high in DONE.
- pc  out  AW  index of the word currently on the bus.

## Operation
- Program store: DEPTH x 17 registers, not reset.
  - Written on a clk edge when load_en=1 and state != ISSUE.
  - load_en is ignored in ISSUE.
- FSM states:
  - IDLE
    - start=1 and 1 <= prog_len <= DEPTH and load_en=0: latch len=prog_len, pc=0, load instruccion=mem[0], go to ISSUE.
    - start with an illegal prog_len is ignored.
    - start together with load_en: the load is performed and start is ignored.
  - ISSUE
    - A hold counter counts 0..HOLD_CYCLES-1.
    - On terminal count with pc < len-1 and no pending stop: pc+1, instruccion=mem[pc+1], counter=0.
    - On terminal count with pc == len-1: go to DONE.
    - stop=1 sets a pending flag. At terminal count the FSM goes to IDLE instead of advancing.
    - start is ignored in ISSUE.
  - DONE
    - done=1.
    - start behaves as in IDLE (restart).
    - stop=1 returns to IDLE.
- instruccion holds its last value outside ISSUE. The datapath has no valid input, so whatever drives the datapath must qualify it with issue_valid.
- issue_valid=busy. first_cycle=busy and counter==0.
- The issuer does no hazard checking. Program order and HOLD_CYCLES must cover the datapath's two pipeline register stages.

## Timing
- Reset values (asynchronous): state=IDLE, instruccion=17'b0, pc=0, counter=0, stop pending=0, issue_valid=0, first_cycle=0, busy=0, done=0.
- Start latency: start sampled at edge k puts mem[0] on the bus, with issue_valid=1 and first_cycle=1, after edge k (one cycle).
- Each word is on the bus for exactly HOLD_CYCLES cycles. Words change back-to-back with no gap cycles.
- A program of N words occupies N*HOLD_CYCLES cycles in ISSUE. done rises on the edge after the last hold cycle.
- stop asserted in the last hold cycle of a word takes effect at that same edge: the next word is not issued.
- Reset asserted mid-program forces IDLE immediately. Program store contents are preserved.
- With prog_len=DEPTH, pc reaches DEPTH-1 and never wraps (non-loop build).

## Configuration
- JERICALLA_ISSUER_LOOP_EN
  - Defined: at terminal count with pc == len-1, pc wraps to 0 and instruccion=mem[0]. DONE is unreachable and the program repeats until stop.
  - Undefined: behaves as described above and terminates in DONE.

## Test plan
- Reset: hold rst_n=0 mid-clock -> all outputs at their reset values immediately, without waiting for a clk edge.
- Basic run, HOLD_CYCLES=2:
  - Load mem[0..3] = 17'b00_00100_00000_00001, 17'b01_00101_00001_00010, 17'b10_00110_00010_00011, 17'b11_00000_00111_00100. Set prog_len=4 and pulse start.
  - Required: each word on the bus for 2 cycles, pc=0,1,2,3, busy for 8 cycles, then done=1 and the bus holds the last word.
- Stop: pulse stop during the first hold cycle of word 1 -> word 1 completes its 2 cycles, FSM returns to IDLE, word 2 is never driven.
- Illegal starts and guarded loads:
  - start with prog_len=0 -> ignored.
  - start with prog_len=17 -> ignored.
  - start together with load_en in IDLE -> write happens, busy stays 0.
  - load_en in ISSUE -> store unchanged.
- Reset mid-program: drop rst_n at pc=2 -> immediate IDLE. A following start reissues from mem[0] with the store intact.
- LOOP_EN build: prog_len=2, HOLD_CYCLES=1 -> bus sequence mem0, mem1, mem0, mem1, … with done never asserted. stop then ends the run after the current word.

Source files
------------

// File: rtl/jericalla_issuer.sv
// jericalla_issuer: instruction issue unit for the Jericalla datapath.
// Holds a DEPTH x 17-bit program store and, after a start pulse, drives the
// datapath instruction bus one word at a time, each for HOLD_CYCLES cycles.
// Optional feature macro: JERICALLA_ISSUER_LOOP_EN -- when defined, the
// program wraps from the last word back to word 0 until stop is requested.
module jericalla_issuer #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [16:0]   load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          stop,
  output logic [16:0]   instruccion,
  output logic          issue_valid,
  output logic          first_cycle,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Terminal value of the per-word hold counter.
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          stop_pend_q, stop_pend_d;
  logic [16:0]   instr_q, instr_d;

  // Program store: plain registers, deliberately left out of reset so a
  // reset in the middle of a run does not lose the loaded program.
  logic [16:0]   mem_q [DEPTH];

  logic          start_ok;
  logic          last_word;
  logic          hold_done;
  logic          stop_seen;
  logic [AW-1:0] pc_inc;

  assign start_ok  = start && !load_en && (prog_len != '0) && (prog_len <= DEPTH_LEN);
  assign last_word = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
  assign hold_done = (cnt_q == HOLD_LAST);
  assign stop_seen = stop_pend_q || stop;
  assign pc_inc    = pc_q + AW'(1);

  // Program store write port; loads are locked out while a program is issuing.
  always_ff @(posedge clk) begin
    if (load_en && (state_q != ISSUE)) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      instr_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      instr_q     <= instr_d;
    end
  end

  // Next-state logic: start/restart, per-word hold counting, advance and stop.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    instr_d     = instr_q;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d     = ISSUE;
          len_d       = prog_len;
          pc_d        = '0;
          cnt_d       = '0;
          stop_pend_d = 1'b0;
          instr_d     = mem_q[0];
        end
      end

      ISSUE: begin
        // Remember a stop request until the current word finishes its hold.
        stop_pend_d = stop_seen;
        if (hold_done) begin
          cnt_d = '0;
          if (stop_seen) begin
            state_d     = IDLE;
            stop_pend_d = 1'b0;
          end else if (last_word) begin
`ifdef JERICALLA_ISSUER_LOOP_EN
            pc_d    = '0;
            instr_d = mem_q[0];
`else
            state_d = DONE;
`endif
          end else begin
            pc_d    = pc_inc;
            instr_d = mem_q[pc_inc];
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      DONE: begin
        // stop takes priority over a simultaneous restart request.
        if (stop) begin
          state_d = IDLE;
        end else if (start_ok) begin
          state_d     = ISSUE;
          len_d       = prog_len;
          pc_d        = '0;
          cnt_d       = '0;
          stop_pend_d = 1'b0;
          instr_d     = mem_q[0];
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign instruccion = instr_q;
  assign busy        = (state_q == ISSUE);
  assign done        = (state_q == DONE);
  assign issue_valid = busy;
  assign first_cycle = busy && (cnt_q == 8'd0);
  assign pc          = pc_q;

endmodule
